// File: rtl/eth_pkg.sv
// Shared Ethernet constants, TX state encoding and the byte-wide CRC-32 step
// used by both the GMII transmitter and the receive-side FCS checker.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int unsigned ETH_MIN_FRAME = 60;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } tx_state_e;

    // Reflected CRC-32, one byte processed LSB first.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-per-cycle CRC-32 register; init has priority over en.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            crc_q <= CRC32_INIT;
        end else if (init) begin
            crc_q <= CRC32_INIT;
        end else if (en) begin
            crc_q <= crc32_d8(crc_q, data);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/eth_gmii_tx.sv
// GMII frame transmitter: buffered payload out as preamble, SFD, data, zero
// padding and FCS, followed by the inter-frame gap.
module eth_gmii_tx
    import eth_pkg::*;
#(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned MIN_FRAME    = ETH_MIN_FRAME,
    parameter int unsigned IFG_CYCLES   = 12,
    parameter int unsigned PREAMBLE_LEN = 7
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              tx_en,
    output logic [7:0]        tx_data
);

    localparam int unsigned    CW        = ADDR_W + 1;
    localparam int unsigned    DEPTH     = 2 ** ADDR_W;
    localparam logic [CW-1:0]  DEPTH_LEN = CW'(DEPTH);
    localparam logic [CW-1:0]  MIN_LEN   = CW'(MIN_FRAME);
    localparam logic [CW-1:0]  PRE_LAST  = CW'(PREAMBLE_LEN - 1);
    localparam logic [CW-1:0]  PAD_LAST  = CW'(MIN_FRAME - 1);
    localparam logic [CW-1:0]  IFG_LAST  = CW'(IFG_CYCLES - 1);
    localparam logic [CW-1:0]  FCS_LAST  = CW'(3);

    tx_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     len_q, len_d;
    logic              tx_en_q, tx_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       crc;
    logic [31:0]       fcs;
    logic [7:0]        byte_out;

    // Address runs one ahead of the byte on the wire so the synchronous read
    // lands exactly when DATA needs it; SFD fetches byte 0.
    assign rd_addr = (state_q == DATA) ? ADDR_W'(cnt_q + CW'(1)) : '0;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q <= mem[rd_addr];
    end

    eth_crc32_d8 u_crc (
        .clock   (clock),
        .reset_n (reset_n),
        .init    (state_q == IDLE && start),
        .en      (state_q == DATA || state_q == PAD),
        .data    (byte_out),
        .crc     (crc)
    );

    assign fcs = ~crc;

    always_comb begin
        byte_out = '0;
        case (state_q)
            PRE:  byte_out = ETH_PREAMBLE;
            SFD:  byte_out = ETH_SFD;
            DATA: byte_out = rd_q;
            FCS: begin
                case (cnt_q[1:0])
                    2'd0:    byte_out = fcs[7:0];
                    2'd1:    byte_out = fcs[15:8];
                    2'd2:    byte_out = fcs[23:16];
                    default: byte_out = fcs[31:24];
                endcase
            end
            default: byte_out = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        tx_en_d = tx_en_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    len_d   = (length > DEPTH_LEN) ? DEPTH_LEN : length;
                    tx_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SFD: begin
                cnt_d   = '0;
                state_d = (len_q != '0) ? DATA : PAD;
            end
            DATA: begin
                if (cnt_q == len_q - CW'(1)) begin
                    // Padding continues the byte count so PAD ends at MIN_FRAME-1.
                    if (len_q < MIN_LEN) begin
                        state_d = PAD;
                        cnt_d   = cnt_q + CW'(1);
                    end else begin
                        state_d = FCS;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PAD: begin
                if (cnt_q == PAD_LAST) begin
                    state_d = FCS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FCS: begin
                if (cnt_q == FCS_LAST) begin
                    state_d = IFG;
                    cnt_d   = '0;
                    tx_en_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_en_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
        done_d = (state_d == IFG) && (cnt_d == IFG_LAST);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            tx_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            tx_en_q <= tx_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_en   = tx_en_q;
    assign tx_data = byte_out;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_eth_gmii_tx.sv
// Self-checking bench for eth_gmii_tx: captured wire frames compared with a
// table-driven CRC frame model built from a shadow copy of the buffer.
module tb_eth_gmii_tx;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;
    localparam int MINF   = 60;
    localparam int IFGC   = 12;
    localparam int PREL   = 7;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en   = 1'b0;
    logic [10:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        start   = 1'b0;
    logic [11:0] length  = '0;
    logic        busy, done, tx_en;
    logic [7:0]  tx_data;

    always #4 clock = ~clock;

    eth_gmii_tx #(
        .ADDR_W       (ADDR_W),
        .MIN_FRAME    (MINF),
        .IFG_CYCLES   (IFGC),
        .PREAMBLE_LEN (PREL)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .length  (length),
        .busy    (busy),
        .done    (done),
        .tx_en   (tx_en),
        .tx_data (tx_data)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_m [DEPTH];
    logic [31:0] crc_tab [256];
    logic [7:0]  cap [$];
    logic [7:0]  exp_q [$];

    int   frames = 0, idle_bad = 0, low_run = 0, last_gap = 0;
    int   cyc = 0, fall_cyc = 0, done_cyc = 0, done_run = 0, done_width = 0;
    logic prev_en = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (tx_en === 1'b1) begin
            cap.push_back(tx_data);
            if (!prev_en) last_gap = low_run;
            low_run = 0;
        end else begin
            if (tx_data !== 8'h00) idle_bad++;
            if (prev_en) begin
                frames++;
                fall_cyc = cyc;
            end
            low_run++;
        end
        if (done === 1'b1) begin
            done_cyc = cyc;
            done_run++;
        end else if (done_run > 0) begin
            done_width = done_run;
            done_run   = 0;
        end
        prev_en = (tx_en === 1'b1);
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        return (c >> 8) ^ crc_tab[c[7:0] ^ b];
    endfunction

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = 11'(a); wr_data = d;
        tick;
        wr_en = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) wr(i, 8'($urandom));
    endtask

    // Frame on the wire = preamble, SFD, payload, zero pad, ~CRC LSB first.
    task automatic build_exp(input int len);
        int l;
        logic [31:0] c;
        l = (len > DEPTH) ? DEPTH : len;
        exp_q.delete();
        for (int i = 0; i < PREL; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < l; i++) begin
            exp_q.push_back(mem_m[i]);
            c = crc_upd(c, mem_m[i]);
        end
        for (int i = l; i < MINF; i++) begin
            exp_q.push_back(8'h00);
            c = crc_upd(c, 8'h00);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    endtask

    task automatic send(input string name, input int len);
        start = 1'b1; length = 12'(len);
        tick;
        start = 1'b0;
        checks++;
        if (tx_en !== 1'b1 || busy !== 1'b1 || tx_data !== 8'h55) begin
            errors++;
            $display("FAIL %s latency: tx_en=%b busy=%b tx_data=%h, want 1 1 55", name, tx_en, busy, tx_data);
        end
    endtask

    task automatic wait_frame(input string name, input int n0, input int budget);
        int k = 0;
        while (frames == n0 && k < budget) begin tick; k++; end
        checks++;
        if (frames == n0) begin
            errors++;
            $display("FAIL %s frame_end: timed out after %0d cycles, want tx_en to fall", name, budget);
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy === 1'b1 && k < 100) begin tick; k++; end
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b, want 0", name, busy);
        end
    endtask

    task automatic check_frame(input string name, input int len);
        int bad;
        logic [31:0] r;
        build_exp(len);
        checks++;
        if (cap.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s tx_en_cycles: got %0d, want %0d", name, cap.size(), exp_q.size());
        end
        bad = -1;
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            if (bad < 0 && cap[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s bytes: index %0d got %h, want %h", name, bad, cap[bad], exp_q[bad]);
        end
        r = 32'hFFFFFFFF;
        for (int i = PREL + 1; i < cap.size(); i++) r = crc_upd(r, cap[i]);
        checks++;
        if (r !== 32'hDEBB20E3) begin
            errors++;
            $display("FAIL %s residue: got %h, want debb20e3", name, r);
        end
        cap.delete();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) tick;
        checks += 4;
        if (tx_en !== 1'b0)      begin errors++; $display("FAIL reset tx_en: got %b, want 0", tx_en); end
        if (tx_data !== 8'h00)   begin errors++; $display("FAIL reset tx_data: got %h, want 00", tx_data); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset busy: got %b, want 0", busy); end
        if (done !== 1'b0)       begin errors++; $display("FAIL reset done: got %b, want 0", done); end
        reset_n = 1'b1;
        tick;
        cap.delete();
    endtask

    task automatic test_check_string;
        int n0;
        for (int i = 0; i < 9; i++) wr(i, 8'h31 + 8'(i));
        n0 = frames;
        send("check9", 9);
        wait_frame("check9", n0, 200);
        check_frame("check9", 9);
        wait_idle("check9");
    endtask

    task automatic test_long;
        int n0;
        for (int i = 0; i < 100; i++) wr(i, 8'(i));
        n0 = frames;
        send("len100", 100);
        wait_frame("len100", n0, 300);
        check_frame("len100", 100);
        wait_idle("len100");
        checks += 2;
        // fall_cyc is the first IFG sample, so the last IFG sample is IFGC-1 later.
        if (done_cyc - fall_cyc != IFGC - 1) begin
            errors++;
            $display("FAIL len100 done_offset: got %0d, want %0d", done_cyc - fall_cyc, IFGC - 1);
        end
        if (done_width != 1) begin
            errors++;
            $display("FAIL len100 done_width: got %0d, want 1", done_width);
        end
    endtask

    task automatic test_zero;
        int n0;
        n0 = frames;
        send("len0", 0);
        wait_frame("len0", n0, 200);
        check_frame("len0", 0);
        wait_idle("len0");
    endtask

    task automatic test_ignored_start;
        int n0, len;
        len = int'($urandom_range(20, 40));
        fill_random(len);
        n0 = frames;
        send("ignore", len);
        repeat (15) tick;
        start = 1'b1; length = 12'($urandom_range(1, 200));
        tick;
        start = 1'b0;
        wait_frame("ignore", n0, 200);
        repeat (3) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (40) tick;
        checks += 2;
        if (frames != n0 + 1) begin
            errors++;
            $display("FAIL ignore frame_count: got %0d, want %0d", frames - n0, 1);
        end
        if (busy !== 1'b0 || tx_en !== 1'b0) begin
            errors++;
            $display("FAIL ignore quiet: busy=%b tx_en=%b, want 0 0", busy, tx_en);
        end
        check_frame("ignore", len);
    endtask

    task automatic test_back_to_back;
        int n0, l1, l2, k;
        l1 = int'($urandom_range(1, 80));
        l2 = int'($urandom_range(1, 80));
        fill_random(80);
        n0 = frames;
        send("b2b_1", l1);
        wait_frame("b2b_1", n0, 200);
        check_frame("b2b_1", l1);
        k = 0;
        while (done !== 1'b1 && k < 50) begin tick; k++; end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b done_seen: got %b, want 1", done);
        end
        tick;
        n0 = frames;
        start = 1'b1; length = 12'(l2);
        tick;
        start = 1'b0;
        wait_frame("b2b_2", n0, 200);
        // Gap is the IFG plus the single IDLE cycle in which start is sampled.
        checks++;
        if (last_gap != IFGC + 1) begin
            errors++;
            $display("FAIL b2b gap: got %0d, want %0d", last_gap, IFGC + 1);
        end
        check_frame("b2b_2", l2);
        wait_idle("b2b_2");
    endtask

    task automatic test_reset_mid;
        int n0, len;
        len = int'($urandom_range(30, 60));
        fill_random(len);
        n0 = frames;
        send("rstmid", 50);
        repeat (20) tick;
        reset_n = 1'b0;
        tick;
        checks += 2;
        if (tx_en !== 1'b0) begin errors++; $display("FAIL rstmid tx_en: got %b, want 0", tx_en); end
        if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid busy: got %b, want 0", busy); end
        reset_n = 1'b1;
        tick;
        cap.delete();
        n0 = frames;
        send("after_rst", len);
        wait_frame("after_rst", n0, 200);
        check_frame("after_rst", len);
        wait_idle("after_rst");
    endtask

    task automatic test_saturate;
        int n0;
        fill_random(DEPTH);
        n0 = frames;
        send("sat", 4095);
        wait_frame("sat", n0, 2300);
        check_frame("sat", 4095);
        wait_idle("sat");
    endtask

    task automatic test_random;
        int n0, len;
        for (int t = 0; t < 3; t++) begin
            len = int'($urandom_range(1, 130));
            fill_random(len);
            n0 = frames;
            send("rand", len);
            wait_frame("rand", n0, 300);
            check_frame("rand", len);
            wait_idle("rand");
        end
    endtask

    initial begin
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;

        test_reset;
        test_check_string;
        test_long;
        test_zero;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid;
        test_saturate;
        test_random;

        checks++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL idle_data: %0d nonzero bytes with tx_en low, want 0", idle_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
